// File: rtl/stream_mux_nx1_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared types and helpers for the stream_mux_nx1 block.
//   mux_mode_t : selection mode (explicit select or round-robin)
//   next_idx   : wrap-around increment of a channel index for any channel
//                count, including counts that are not a power of two.
// ---------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_t;

    // Channel counts need not be powers of two, so the wrap is an explicit
    // compare rather than relying on index overflow.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: finds the first requester starting at ptr
// and searching upward with wrap-around.
//   req     in  N      request vector
//   ptr     in  SEL_W  highest-priority index (must be < N)
//   gnt_idx out SEL_W  granted index (0 when nothing requests)
//   gnt_any out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [SEL_W:0]   w_sum [N];
    logic [SEL_W-1:0] w_idx [N];
    logic [N-1:0]     w_rot;

    // Rotation: position gi of w_rot is the channel (ptr + gi) mod N. The
    // modulo is a single conditional subtract since both terms are < N.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign w_sum[gi] = {1'b0, ptr} + (SEL_W+1)'(gi);
        assign w_idx[gi] = (w_sum[gi] >= (SEL_W+1)'(N))
                         ? SEL_W'(w_sum[gi] - (SEL_W+1)'(N))
                         : SEL_W'(w_sum[gi]);
        assign w_rot[gi] = req[w_idx[gi]];
    end

    // Priority-encode the lowest rotated position; its w_idx entry is the
    // unrotated channel number.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                gnt_any = 1'b1;
                gnt_idx = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// ---------------------------------------------------------------------------
// stream_mux_nx1
// N-input, WIDTH-bit valid/ready stream multiplexer with a registered output
// stage. Channel selection is either explicit (sel) or fair round-robin.
//   clk       in  1            rising-edge clock
//   rst       in  1            synchronous active-high reset
//   mode      in  1            0 = explicit select, 1 = round-robin
//   sel       in  SEL_W        channel index used in explicit-select mode
//   in_data   in  N_IN*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   in_valid  in  N_IN         per-channel valid
//   in_ready  out N_IN         per-channel ready (combinational)
//   out_data  out WIDTH        registered data
//   out_src   out SEL_W        registered source channel of out_data
//   out_valid out 1            registered valid
//   out_ready in  1            downstream ready
// ---------------------------------------------------------------------------
module stream_mux_nx1
    import mux_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_src;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    mux_mode_t        w_mode;
    logic             w_load_en;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_gnt_any;
    logic [SEL_W-1:0] w_src;
    logic             w_xfer;
    logic [WIDTH-1:0] w_chan [N_IN];

    assign w_mode = mux_mode_t'(mode);

    // The output register can take a beat when empty or when it drains this
    // cycle, giving one beat per cycle without a bubble.
    assign w_load_en = !r_out_valid || out_ready;

    rr_arbiter #(.N(N_IN)) u_arb (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign w_src = (w_mode == MODE_RR) ? w_gnt_idx : sel;

    // An out-of-range sel matches no channel, so nothing becomes ready.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
        assign w_chan[gi]   = in_data[gi*WIDTH +: WIDTH];
        assign in_ready[gi] = !rst && w_load_en &&
                              ((w_mode == MODE_RR) ? (w_gnt_any && (w_gnt_idx == SEL_W'(gi)))
                                                   : (sel == SEL_W'(gi)));
    end

    assign w_xfer = |(in_valid & in_ready);

    // w_chan is only indexed when a transfer occurs, which guarantees
    // w_src addresses a real channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_chan[w_src];
            r_out_src   <= w_src;
            if (w_mode == MODE_RR) begin
                r_rr_ptr <= SEL_W'(next_idx(32'(w_src), 32'(N_IN)));
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_nx1
// Drives an 8-channel and a 5-channel instance side by side. A reference
// model tracks the output register and round-robin pointer as plain integers
// and derives the expected ready vector from the selection rules each cycle.
// ---------------------------------------------------------------------------
module tb_stream_mux_nx1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-channel instance
    logic        rst8, mode8, ov8, ordy8;
    logic [2:0]  sel8, os8;
    logic [63:0] data8;
    logic [7:0]  v8, rdy8, od8;

    // 5-channel instance
    logic        rst5, mode5, ov5, ordy5;
    logic [2:0]  sel5, os5;
    logic [39:0] data5;
    logic [4:0]  v5, rdy5;
    logic [7:0]  od5;

    stream_mux_nx1 #(.N_IN(8), .WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .mode(mode8), .sel(sel8), .in_data(data8),
        .in_valid(v8), .in_ready(rdy8), .out_data(od8), .out_src(os8),
        .out_valid(ov8), .out_ready(ordy8)
    );

    stream_mux_nx1 #(.N_IN(5), .WIDTH(8)) u_dut5 (
        .clk(clk), .rst(rst5), .mode(mode5), .sel(sel5), .in_data(data5),
        .in_valid(v5), .in_ready(rdy5), .out_data(od5), .out_src(os5),
        .out_valid(ov5), .out_ready(ordy5)
    );

    int n_cmp = 0;
    int n_err = 0;

    int m_valid [2];
    int m_data  [2];
    int m_src   [2];
    int m_ptr   [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chan_count(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    function automatic int chan_data(input int d, input int c);
        if (d == 0) return int'(data8[c*8 +: 8]);
        return int'(data5[c*8 +: 8]);
    endfunction

    // Expected ready vector derived from the selection rules.
    function automatic logic [63:0] exp_ready(input int d);
        logic [63:0] res;
        logic        r, md, ordy, found;
        int          s, n, g;
        logic [63:0] v;
        res = '0;
        n = chan_count(d);
        if (d == 0) begin
            r = rst8; md = mode8; ordy = ordy8; s = int'(sel8); v = {56'b0, v8};
        end else begin
            r = rst5; md = mode5; ordy = ordy5; s = int'(sel5); v = {59'b0, v5};
        end
        if (r) return res;
        if (m_valid[d] != 0 && !ordy) return res;
        if (!md) begin
            if (s < n) res[s] = 1'b1;
        end else begin
            found = 1'b0;
            for (int k = 0; k < n; k++) begin
                g = (m_ptr[d] + k) % n;
                if (!found && v[g]) begin
                    res[g] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // One clock: check readies, advance the model across the edge, check outputs.
    task automatic step();
        int          nv [2], nd [2], ns [2], np [2];
        logic [63:0] er, v, xf;
        logic        r, md, ordy;
        int          idx;
        #1;
        for (int d = 0; d < 2; d++) begin
            er = exp_ready(d);
            if (d == 0) begin
                check_val("rdy8", {56'b0, rdy8}, er);
                r = rst8; md = mode8; ordy = ordy8; v = {56'b0, v8};
            end else begin
                check_val("rdy5", {59'b0, rdy5}, er);
                r = rst5; md = mode5; ordy = ordy5; v = {59'b0, v5};
            end
            nv[d] = m_valid[d]; nd[d] = m_data[d]; ns[d] = m_src[d]; np[d] = m_ptr[d];
            xf = er & v;
            if (r) begin
                nv[d] = 0; nd[d] = 0; ns[d] = 0; np[d] = 0;
            end else if (xf != 0) begin
                idx = 0;
                for (int c = 0; c < 64; c++) if (xf[c]) idx = c;
                nv[d] = 1;
                nd[d] = chan_data(d, idx);
                ns[d] = idx;
                if (md) np[d] = (idx + 1) % chan_count(d);
            end else if (ordy) begin
                nv[d] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = nv[d]; m_data[d] = nd[d]; m_src[d] = ns[d]; m_ptr[d] = np[d];
        end
        check_val("ov8", {63'b0, ov8}, 64'(m_valid[0]));
        check_val("ov5", {63'b0, ov5}, 64'(m_valid[1]));
        if (m_valid[0] != 0) begin
            check_val("od8", {56'b0, od8}, 64'(m_data[0]));
            check_val("os8", {61'b0, os8}, 64'(m_src[0]));
        end
        if (m_valid[1] != 0) begin
            check_val("od5", {56'b0, od5}, 64'(m_data[1]));
            check_val("os5", {61'b0, os5}, 64'(m_src[1]));
        end
        @(negedge clk);
    endtask

    int rr_seq8 [6] = '{0, 3, 7, 0, 3, 7};
    int rr_seq5 [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_data[d] = 0; m_src[d] = 0; m_ptr[d] = 0;
        end
        rst8 = 1'b1; mode8 = 1'b0; sel8 = 3'd0; data8 = '1; v8 = 8'hFF; ordy8 = 1'b1;
        rst5 = 1'b1; mode5 = 1'b0; sel5 = 3'd0; data5 = '1; v5 = 5'h1F; ordy5 = 1'b1;
        @(negedge clk);

        // Reset held with every input valid.
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("rst_ov", {63'b0, ov8}, 64'd0);
            check_val("rst_od", {56'b0, od8}, 64'd0);
            check_val("rst_os", {61'b0, os8}, 64'd0);
        end
        rst8 = 1'b0; rst5 = 1'b0; v5 = 5'h0;

        // Explicit select of channel 5.
        sel8 = 3'd5; data8 = 64'h0; data8[5*8 +: 8] = 8'hA5;
        #1;
        check_val("sel5_rdy", {56'b0, rdy8}, 64'h20);
        step();
        check_val("sel5_data", {56'b0, od8}, 64'hA5);
        check_val("sel5_src", {61'b0, os8}, 64'd5);
        for (int i = 0; i < 4; i++) begin
            data8 = {$urandom, $urandom};
            step();
        end

        // Backpressure with a beat held.
        ordy8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data8 = {$urandom, $urandom};
            step();
        end
        ordy8 = 1'b1;
        data8[5*8 +: 8] = 8'h3C;
        step();
        check_val("bp_resume", {56'b0, od8}, 64'h3C);

        // Round-robin fairness and wrap from channel 7.
        mode8 = 1'b1; v8 = 8'b1000_1001;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("rr_seq8", {61'b0, os8}, 64'(rr_seq8[i]));
        end
        v8 = 8'h80;
        step();
        check_val("rr_single7", {61'b0, os8}, 64'd7);
        v8 = 8'hFF;
        step();
        check_val("rr_wrap0", {61'b0, os8}, 64'd0);

        // Five-channel build: wrap past index 4, then out-of-range select.
        v8 = 8'h00;
        mode5 = 1'b1; v5 = 5'h1F; data5 = {$urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("rr_seq5", {61'b0, os5}, 64'(rr_seq5[i]));
        end
        mode5 = 1'b0; sel5 = 3'd6;
        #1;
        check_val("sel6_rdy", {59'b0, rdy5}, 64'd0);
        step();
        check_val("sel6_drain", {63'b0, ov5}, 64'd0);

        // Reset while a beat is held under backpressure.
        mode8 = 1'b1; v8 = 8'hFF; ordy8 = 1'b1;
        step();
        ordy8 = 1'b0;
        step();
        rst8 = 1'b1;
        step();
        check_val("midrst_ov", {63'b0, ov8}, 64'd0);
        rst8 = 1'b0; ordy8 = 1'b1;
        step();
        check_val("midrst_gnt0", {61'b0, os8}, 64'd0);

        // Randomised traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            rst8  = ($urandom_range(0, 31) == 0);
            rst5  = ($urandom_range(0, 31) == 0);
            mode8 = 1'($urandom_range(0, 1));
            mode5 = 1'($urandom_range(0, 1));
            sel8  = 3'($urandom_range(0, 7));
            sel5  = 3'($urandom_range(0, 7));
            v8    = 8'($urandom);
            v5    = 5'($urandom);
            ordy8 = ($urandom_range(0, 3) != 0);
            ordy5 = ($urandom_range(0, 3) != 0);
            data8 = {$urandom, $urandom};
            data5 = 40'({$urandom, $urandom});
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_nx1.md
Name: stream_mux_nx1

Overview:
- Parametrised N-input, W-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Generalises the gate-level 2/4/8-to-1 muxes in three ways: any width, any channel count, and a registered output.
- Two selection modes: explicit select, or fair round-robin arbitration across requesting inputs.
- Sits between multiple producers (e.g. lab datapath channels) and a single downstream consumer.

Parameters:
- N_IN, 8, number of input channels; legal range 2..64, power of two not required.
- WIDTH, 8, data bits per channel.
- SEL_W, $clog2(N_IN), select/index width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = MODE_SEL (explicit select), 1 = MODE_RR (round-robin).
- sel  in  SEL_W  channel index; used only in MODE_SEL.
- in_data  in  N_IN*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_IN  per-channel valid.
- in_ready  out  N_IN  per-channel ready; combinational.
- out_data  out  WIDTH  registered output data.
- out_src  out  SEL_W  registered index of the channel that supplied out_data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (rst high at a clock edge):
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - in_ready is 0 on every channel while rst is high.
  - A beat held in the output register is discarded; no partial-transfer state survives.
- load_en = !out_valid || out_ready. This allows one beat per cycle at full throughput.
- in_ready is combinational from out_ready, mode, sel, in_valid and rr_ptr. There is no combinational path from in_data to any output.
- MODE_SEL:
  - in_ready[i] = load_en && (i == sel).
  - If sel >= N_IN, every in_ready is 0 and nothing loads.
- MODE_RR:
  - grant = first index g with in_valid[g]=1, searching rr_ptr, rr_ptr+1, ..., N_IN-1, 0, ..., rr_ptr-1.
  - in_ready[grant] = load_en. All other in_ready bits are 0.
  - If no input is valid, every in_ready is 0.
- Transfer on channel i: in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= channel i data, out_src <= i, out_valid <= 1.
  - In MODE_RR only: rr_ptr <= (i == N_IN-1) ? 0 : i+1. The wrap must be explicit, because N_IN is not required to be a power of two.
- Output side:
  - If out_ready=1 and no transfer occurs, out_valid <= 0.
  - If out_valid=1 and out_ready=0, out_data and out_src hold stable and every in_ready is 0.
- Latency: 1 cycle from input transfer to out_valid.
- Simultaneous output drain and new load in the same cycle: the new beat replaces the old one, out_valid stays 1, no bubble.
- Changing mode or sel never corrupts a held beat; the change only affects which channel is selected at the next load.
- rr_ptr holds its value in MODE_SEL and resumes from there on return to MODE_RR.
- Inputs must not drop in_valid before their transfer completes. Violations are not checked.

Decomposition:
- Package mux_pkg:
  - typedef enum logic {MODE_SEL=1'b0, MODE_RR=1'b1} mux_mode_t.
  - Helper function next_idx(idx, n) implementing the wrap-around increment.
- Sub-module rr_arbiter:
  - Purely combinational.
  - Parameter N.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_any.
  - Implementation: rotate, priority-encode, unrotate.
- The top level holds the output register, rr_ptr and the handshake logic.

Test Plan:
- Reset/idle: rst held high for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0 throughout. First transfer occurs in the cycle after rst falls.
- MODE_SEL, N_IN=8, WIDTH=8, sel=5, in_valid=8'hFF, channel 5 data=8'hA5, out_ready=1 -> only in_ready[5]=1. Next cycle out_data=8'hA5, out_src=5, out_valid=1. Back-to-back beats arrive every cycle.
- Backpressure: out_ready=0 for 4 cycles after one beat is held -> out_data and out_src stable, in_ready=0. Raising out_ready accepts a new beat the same cycle with no bubble.
- MODE_RR fairness: in_valid=8'b1000_1001, out_ready=1 -> out_src sequence 0,3,7,0,3,7. With a single requester on channel 7, the next grant is 7 and rr_ptr wraps to 0.
- Non-power-of-two build, N_IN=5: channel 4 granted -> rr_ptr=0, never 5. MODE_SEL with sel=6 -> no in_ready asserted and out_valid drops after the drain.
- Reset mid-operation: out_valid=1 with out_ready=0, then rst pulsed for 1 cycle -> beat lost, out_valid=0, rr_ptr=0. The next MODE_RR grant with all inputs valid is channel 0.
